// File: rtl/adder_mem_pkg.sv
// Shared types and elaboration helpers for the parametrised on-chip RAM slave.
package adder_mem_pkg;

    typedef enum logic [1:0] {
        RST  = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned BE_W = 32 / 8;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic bit latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic int unsigned index_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/adder_onchip_ram_pipe_if.sv
// Avalon-MM slave bus bundle for the on-chip RAM.
interface adder_onchip_ram_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/adder_ram_core.sv
// Inferred single-port byte-enable RAM with one registered read stage.
module adder_ram_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4093,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   ce,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W/8-1:0]    be,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      q
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
            q <= mem[addr];
        end
    end
endmodule

// File: rtl/adder_onchip_ram_pipe.sv
// Avalon-MM on-chip RAM slave: optional zero-fill, range check, 1- or 2-cycle read pipeline.
module adder_onchip_ram_pipe
    import adder_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 4093,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    adder_onchip_ram_pipe_if.slave bus,
    input  logic                  clken,
    input  logic                  reset_req,
    output logic                  init_done,
    output logic                  addr_err
);
    localparam int unsigned BE_LEN = be_width(DATA_W);
    localparam int unsigned IDX_W  = index_width(DEPTH);
    localparam bit          LAT2   = latency_ok(READ_LATENCY) && (READ_LATENCY == 2);

    state_t             state, state_next;
    logic [IDX_W-1:0]   fill_addr, fill_next;
    logic               en, filling, in_range, accept, do_write, do_read;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_addr;
    logic [BE_LEN-1:0]  ram_be;
    logic [DATA_W-1:0]  ram_wdata, ram_q, rd_s1, rdata;
    logic               v1, z1, rdv;

    assign en        = clken & ~reset_req;
    assign filling   = (state == FILL);
    assign init_done = (state == RUN);
    assign bus.waitrequest = (state != RUN) | ~en;

    assign in_range = {1'b0, bus.address} < (ADDR_W+1)'(DEPTH);
    assign accept   = bus.chipselect & ~bus.waitrequest & (bus.read | bus.write);
    assign do_write = accept & bus.write;
    assign do_read  = accept & bus.read & ~bus.write;

    always_comb begin
        state_next = state;
        fill_next  = fill_addr;
        case (state)
            RST:  if (en) state_next = CLEAR_ON_RESET ? FILL : RUN;
            FILL: if (en) begin
                if (fill_addr == IDX_W'(DEPTH - 1)) begin
                    state_next = RUN;
                    fill_next  = '0;
                end else begin
                    fill_next  = fill_addr + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST;
            fill_addr <= '0;
        end else if (en) begin
            state     <= state_next;
            fill_addr <= fill_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   addr_err <= 1'b0;
        else if (accept & ~in_range) addr_err <= 1'b1;
    end

    assign ram_we    = filling | (do_write & in_range);
    assign ram_addr  = filling ? fill_addr : bus.address[IDX_W-1:0];
    assign ram_be    = filling ? '1 : bus.byteenable;
    assign ram_wdata = filling ? '0 : bus.writedata;

    adder_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_core (
        .clk   (clk),
        .ce    (en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // z1 marks an out-of-range read so the stale core output is replaced by zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            z1 <= 1'b0;
        end else if (en) begin
            v1 <= do_read;
            z1 <= ~in_range;
        end
    end

    assign rd_s1 = (v1 & ~z1) ? ram_q : '0;

    if (LAT2) begin : g_stage2
        logic              v2;
        logic [DATA_W-1:0] d2;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else if (en) begin
                v2 <= v1;
                d2 <= rd_s1;
            end
        end
        assign rdv   = v2;
        assign rdata = d2;
    end else begin : g_stage1
        assign rdv   = v1;
        assign rdata = rd_s1;
    end

    // Gating with en keeps a stalled pulse from being seen on more than one edge
    assign bus.readdatavalid = rdv & en;
    assign bus.readdata      = rdata;
endmodule

// File: doc/adder_onchip_ram_pipe.md
Name: adder_onchip_ram_pipe

Overview:
- Parametrised Avalon-MM single-port on-chip RAM slave for the Nios II subsystem; next generation of the fixed 32-bit, unregistered on-chip memory.
- Adds configurable data width, depth and read latency (1 or 2), explicit waitrequest/readdatavalid handshake, optional zero-fill after reset, and out-of-range address detection.
- Sits on the system interconnect as an instruction/data memory or scratch buffer.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, range 8..128.
- DEPTH, 4093, number of words; need not be a power of two.
- ADDR_W, 12, address width; must satisfy 2**ADDR_W >= DEPTH.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 0, 1 = zero-fill all words after reset before accepting traffic.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  per-byte write enable.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- clken  in  1  clock enable.
- reset_req  in  1  reset-request hold; freezes the RAM like clken=0.
- readdata  out  DATA_W  read data; meaningful only while readdatavalid=1.
- readdatavalid  out  1  single-cycle pulse per accepted read.
- waitrequest  out  1  slave not ready.
- init_done  out  1  high once zero-fill completes; stays high until reset.
- addr_err  out  1  sticky flag, set by any out-of-range access.

Behaviour:
- Reset values: readdata=0, readdatavalid=0, waitrequest=1, init_done=0, addr_err=0. Read pipeline is flushed.
- The clock and reset are the single clk and the asynchronous active-high reset; there is no other clock or reset domain.
- en = clken & ~reset_req. When en=0: all state (FSM, fill counter, pipeline) holds and waitrequest=1.
- FSM states:
  - RST: entered on reset. Moves to FILL on the first en cycle if CLEAR_ON_RESET=1, otherwise to RUN.
  - FILL: writes all-zero, full byteenable to fill_addr, counting 0..DEPTH-1, one word per en cycle; waitrequest=1. After word DEPTH-1 is written, moves to RUN, sets init_done=1 and clears the counter.
  - RUN: waitrequest = ~en. init_done=1. This holds even when CLEAR_ON_RESET=0 (init_done rises one cycle after reset release).
- Accept rule: access accepted when chipselect & ~waitrequest & (read | write) on a rising edge.
- Write:
  - Only bytes with byteenable=1 are updated; the others are preserved.
  - The update is visible to a read accepted on the next cycle; no bypass is needed within the same cycle.
- Read:
  - READ_LATENCY=1: readdata and readdatavalid are valid on the edge after acceptance.
  - READ_LATENCY=2: one extra output register stage.
  - Fully pipelined: one read per cycle, back to back, with no bubbles.
- read & write asserted together: the write is performed, the read is dropped (no readdatavalid), and addr_err is unaffected.
- Address >= DEPTH:
  - Write: dropped, memory unchanged.
  - Read: returns 0 with a normal readdatavalid pulse.
  - Both set addr_err (sticky; cleared only by reset).
- Byteenable=0 on a write: accepted, no memory change.
- Reset asserted mid-operation: in-flight reads are lost and no readdatavalid is issued. Memory contents are not cleared by reset itself; zero-fill is redone only if CLEAR_ON_RESET=1. Loss of pipeline state on deassertion is allowed.
- en dropping while a read is in flight: the pipeline stalls and resumes when en returns; the pulse is delayed, never lost or duplicated.

Decomposition:
- Shared package adder_mem_pkg:
  - FSM state enum {RST, FILL, RUN}.
  - Localparam BE_W = DATA_W/8.
  - Latency legality check constant.
- Sub-module adder_ram_core:
  - Inferred byte-enable single-port synchronous RAM array; DATA_W, DEPTH, ADDR_W.
  - Read data registered once.
- The top level holds the FSM, fill counter, range check, the optional second output stage and the readdatavalid shift register.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=16 -> waitrequest high for exactly 16 en cycles (plus the RST cycle); init_done rises; read of addr 5 returns 0x00000000.
- Write 0xDEADBEEF to addr 3 with byteenable=4'b1111, then byteenable=4'b0010 with data 0x0000AA00 -> read returns 0xDEADAAEF, with readdatavalid exactly READ_LATENCY cycles after acceptance, for both latencies.
- 8 back-to-back reads of addrs 0..7, preloaded with the value addr*0x11 -> 8 consecutive readdatavalid pulses in order, no gaps.
- Read addr 4093 with DEPTH=4093 -> readdata 0, readdatavalid pulses, addr_err=1 and stays 1; write to 4095 leaves all memory unchanged.
- Deassert clken for 3 cycles mid-read-stream, and separately assert reset_req -> waitrequest high, readdatavalid pulses delayed by 3 cycles, none lost or duplicated.
- Assert reset while 2 reads are in flight -> no readdatavalid afterwards, outputs at reset values, previously written data at addr 3 still reads 0xDEADAAEF when CLEAR_ON_RESET=0.
